uart_cmd_decoder: RTL
=====================

# uart_cmd_decoder

- Receive-side command front end for the Game of Life board; sits between `UARTReceiver` and the simulation controller.
- Consumes bytes over a valid/ready handshake and decodes single-byte and multi-byte commands.
- Presents each decoded command to the controller as a one-entry, held command register.
- Rejects malformed or stalled input with an error pulse.

## Interface
Parameters:
- `CLOCK_FREQ`, 24000000: clock rate in Hz (informational; timeout is in cycles).
- `TIMEOUT_CYCLES`, 2400000: idle cycles allowed between argument bytes (100 ms at 24 MHz).
- `logWIDTH`, 3: log2 of board width; legal range 1..3.
- `logHEIGHT`, 3: log2 of board height; legal range 1..3.

Ports:
- `clk` in 1: clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: byte from `UARTReceiver`.
- `rx_valid` in 1: byte available.
- `rx_ready` out 1: decoder can accept a byte.
- `cmd_valid` out 1: command register full.
- `cmd_code` out 3: 1=STEP, 2=TOGGLE_RUN, 3=RANDOMIZE, 4=CLEAR, 5=SET_CELL, 6=HELP.
- `cmd_addr` out logWIDTH+logHEIGHT: SET_CELL cell index, y<<logWIDTH | x.
- `cmd_value` out 1: SET_CELL state.
- `cmd_ready` in 1: controller takes the command.
- `err_pulse` out 1: one-cycle error strobe.
- `echo_data` out 8: echoed byte.
- `echo_valid` out 1: echo byte pending.
- `echo_ready` in 1: `UARTTransmitter` side accepts the echo byte.

## Operation
- Byte accept: a byte is accepted on any cycle where `rx_valid & rx_ready`.
- `rx_ready` is a registered output. It is high only when all of the following hold:
  - the state is IDLE or ARG_X/ARG_Y/ARG_V;
  - `cmd_valid` is 0;
  - the echo buffer is empty;
  - no byte was accepted in the previous cycle (one-cycle bubble after each accept).
- Letter case folding: letters are folded to lowercase by OR-ing 0x20. This applies to letters only.
- States: IDLE, ARG_X, ARG_Y, ARG_V.
- IDLE decode:
  - '1' or 'n' → STEP.
  - ' ' → TOGGLE_RUN.
  - '0' or 'r' → RANDOMIZE.
  - 'c' → CLEAR.
  - '?' or 'h' → HELP.
  - 's' → go to ARG_X.
  - CR (13) and LF (10) are ignored silently.
  - Any other byte → `err_pulse`, stay in IDLE.
- ARG_X accepts '0' through '0'+WIDTH-1 and latches x. ARG_Y accepts '0' through '0'+HEIGHT-1 and latches y. ARG_V accepts '0' or '1'; it then loads SET_CELL and returns to IDLE.
- In any ARG state:
  - ESC (27) aborts silently to IDLE.
  - Any other illegal byte → `err_pulse`, discard the partial command, go to IDLE.
- Timeout counter:
  - Cleared on entry to any ARG state and on every accepted byte.
  - Increments each cycle while in an ARG state.
  - On reaching TIMEOUT_CYCLES-1 → `err_pulse`, go to IDLE.
  - Held at 0 while in IDLE.
- Command register:
  - `cmd_code`, `cmd_addr` and `cmd_value` are loaded together with `cmd_valid`=1.
  - They are held stable until a cycle with `cmd_valid & cmd_ready`; `cmd_valid` clears on the next cycle.
  - `cmd_addr` and `cmd_value` are 0 for every code except SET_CELL.
- Reset values:
  - All outputs 0, state IDLE, timeout 0, echo buffer empty.
  - `rx_ready` rises on the first cycle after reset deasserts.
  - Reset mid-command discards any partial arguments and any pending command or echo byte.

## Timing
- Cycle N: final command byte accepted. Cycle N+1: `cmd_valid`=1 with all fields stable.
- `cmd_ready` high at N+1: `cmd_valid`=0 at N+2 and `rx_ready`=1 at N+2.
- Sustained throughput: at most one byte every 2 cycles. UART rate never approaches this.
- `err_pulse` is high exactly in the cycle after the offending accept or timeout expiry. It never coincides with `cmd_valid` rising.
- Timeout and byte accept in the same cycle: the accept wins and the counter clears.
- `cmd_ready` while `cmd_valid`=0: ignored.

## Configuration
- Macro: `UART_CMD_DECODER_ECHO_EN`.
- Defined:
  - Every accepted byte, including ignored and erroneous ones, is copied into a one-entry echo buffer at the cycle after accept.
  - `echo_valid` stays high until `echo_ready`.
  - `rx_ready` additionally requires the echo buffer to be empty.
- Undefined:
  - `echo_valid` and `echo_data` are tied to 0 and `echo_ready` is ignored.
  - No echo-related stall occurs.
  - Port list is identical in both builds.

## Test plan
- Reset, then send 'N' with `cmd_ready`=1 → one-cycle `cmd_valid`, `cmd_code`=1, `cmd_addr`=0, `cmd_value`=0.
- Send 's','5','2','1' → `cmd_code`=5, `cmd_addr`=21, `cmd_value`=1, held 10 cycles with `cmd_ready`=0 and `rx_ready`=0 throughout.
- Send 's','8' → `err_pulse` for one cycle, state IDLE; a following ' ' yields `cmd_code`=2.
- Send 's','3', then nothing for TIMEOUT_CYCLES (set to 100 in the bench) → exactly one `err_pulse`, no command.
- Send 's', ESC → no `err_pulse`, no command. Send CR, LF → no `err_pulse`. Send 'x' → one `err_pulse`.
- With `UART_CMD_DECODER_ECHO_EN` defined and `echo_ready`=0 → first byte echoed; `rx_ready` stays 0 until `echo_ready` pulses. Undefined: `echo_valid` stays 0.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns the UART byte stream into held commands for the
// Game of Life controller. It handles single-byte commands, SET_CELL
// ('s' x y v), an argument timeout, and an error strobe for bad input.
// Optional byte echo is built when UART_CMD_DECODER_ECHO_EN is defined.
module uart_cmd_decoder #(
    parameter int CLOCK_FREQ     = 24000000,
    parameter int TIMEOUT_CYCLES = 2400000,
    parameter int logWIDTH       = 3,
    parameter int logHEIGHT      = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    output logic                          cmd_valid,
    output logic [2:0]                    cmd_code,
    output logic [logWIDTH+logHEIGHT-1:0] cmd_addr,
    output logic                          cmd_value,
    input  logic                          cmd_ready,
    output logic                          err_pulse,
    output logic [7:0]                    echo_data,
    output logic                          echo_valid,
    input  logic                          echo_ready
);

    localparam int AW = logWIDTH + logHEIGHT;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    // First byte value beyond the legal digit range for each argument
    localparam logic [7:0] X_END = 8'(48 + (1 << logWIDTH));
    localparam logic [7:0] Y_END = 8'(48 + (1 << logHEIGHT));

    localparam logic [2:0] CODE_STEP  = 3'd1;
    localparam logic [2:0] CODE_RUN   = 3'd2;
    localparam logic [2:0] CODE_RAND  = 3'd3;
    localparam logic [2:0] CODE_CLEAR = 3'd4;
    localparam logic [2:0] CODE_SET   = 3'd5;
    localparam logic [2:0] CODE_HELP  = 3'd6;

    // Elaboration-time sanity check of the configuration
    generate
        if (logWIDTH < 1 || logWIDTH > 3 || logHEIGHT < 1 || logHEIGHT > 3 ||
            TIMEOUT_CYCLES < 2 || CLOCK_FREQ < 1) begin : g_param_check
            $error("uart_cmd_decoder: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ARG_X, ARG_Y, ARG_V} state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [logWIDTH-1:0]   x_reg, x_next;
    logic [logHEIGHT-1:0]  y_reg, y_next;
    logic                  cmd_valid_reg, cmd_valid_next;
    logic [2:0]            cmd_code_reg, cmd_code_next;
    logic [AW-1:0]         cmd_addr_reg, cmd_addr_next;
    logic                  cmd_value_reg, cmd_value_next;
    logic                  err_reg, err_next;
    logic                  rx_ready_reg, rx_ready_next;
    logic                  echo_busy_next;

    logic                  accept;
    logic                  is_letter;
    logic [7:0]            folded;
    logic                  new_cmd;
    logic [2:0]            new_code;
    logic [AW-1:0]         new_addr;
    logic                  new_value;

    assign accept    = rx_valid & rx_ready_reg;
    // Only letters are case-folded; punctuation such as '@' must stay distinct
    assign is_letter = (rx_data >= 8'h41 && rx_data <= 8'h5A) ||
                       (rx_data >= 8'h61 && rx_data <= 8'h7A);
    assign folded    = is_letter ? (rx_data | 8'h20) : rx_data;

    // Next-state decode, argument capture, timeout and command-register update
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        cmd_valid_next = cmd_valid_reg;
        cmd_code_next  = cmd_code_reg;
        cmd_addr_next  = cmd_addr_reg;
        cmd_value_next = cmd_value_reg;
        err_next       = 1'b0;
        new_cmd        = 1'b0;
        new_code       = 3'd0;
        new_addr       = '0;
        new_value      = 1'b0;

        if (cmd_valid_reg && cmd_ready) begin
            cmd_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (accept) begin
                    case (folded)
                        8'h31, 8'h6E: begin new_cmd = 1'b1; new_code = CODE_STEP;  end
                        8'h20:        begin new_cmd = 1'b1; new_code = CODE_RUN;   end
                        8'h30, 8'h72: begin new_cmd = 1'b1; new_code = CODE_RAND;  end
                        8'h63:        begin new_cmd = 1'b1; new_code = CODE_CLEAR; end
                        8'h3F, 8'h68: begin new_cmd = 1'b1; new_code = CODE_HELP;  end
                        8'h73:        state_next = ARG_X;
                        8'h0D, 8'h0A: ;
                        default:      err_next = 1'b1;
                    endcase
                end
            end
            ARG_X, ARG_Y, ARG_V: begin
                if (accept) begin
                    // Any accepted byte restarts the inter-byte timer
                    count_next = '0;
                    if (rx_data == 8'h1B) begin
                        state_next = IDLE;
                    end else if (state_reg == ARG_X && rx_data >= 8'h30 && rx_data < X_END) begin
                        x_next     = rx_data[logWIDTH-1:0];
                        state_next = ARG_Y;
                    end else if (state_reg == ARG_Y && rx_data >= 8'h30 && rx_data < Y_END) begin
                        y_next     = rx_data[logHEIGHT-1:0];
                        state_next = ARG_V;
                    end else if (state_reg == ARG_V && (rx_data == 8'h30 || rx_data == 8'h31)) begin
                        new_cmd    = 1'b1;
                        new_code   = CODE_SET;
                        new_addr   = {y_reg, x_reg};
                        new_value  = rx_data[0];
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else if (count_reg == COUNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (new_cmd) begin
            cmd_valid_next = 1'b1;
            cmd_code_next  = new_code;
            cmd_addr_next  = new_addr;
            cmd_value_next = new_value;
        end
    end

    // Ready is registered: blocked by a full command register, a pending echo
    // byte, or an accept in this cycle (the one-cycle bubble)
    assign rx_ready_next = !accept && !cmd_valid_next && !echo_busy_next;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_code_reg  <= 3'd0;
            cmd_addr_reg  <= '0;
            cmd_value_reg <= 1'b0;
            err_reg       <= 1'b0;
            rx_ready_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_code_reg  <= cmd_code_next;
            cmd_addr_reg  <= cmd_addr_next;
            cmd_value_reg <= cmd_value_next;
            err_reg       <= err_next;
            rx_ready_reg  <= rx_ready_next;
        end
    end

    assign rx_ready  = rx_ready_reg;
    assign cmd_valid = cmd_valid_reg;
    assign cmd_code  = cmd_code_reg;
    assign cmd_addr  = cmd_addr_reg;
    assign cmd_value = cmd_value_reg;
    assign err_pulse = err_reg;

`ifdef UART_CMD_DECODER_ECHO_EN
    logic       echo_valid_reg, echo_valid_next;
    logic [7:0] echo_data_reg, echo_data_next;

    // One-entry echo buffer: filled with the raw byte on every accept
    always_comb begin
        echo_valid_next = echo_valid_reg;
        echo_data_next  = echo_data_reg;
        if (accept) begin
            echo_valid_next = 1'b1;
            echo_data_next  = rx_data;
        end else if (echo_valid_reg && echo_ready) begin
            echo_valid_next = 1'b0;
        end
    end

    // Echo buffer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_valid_reg <= 1'b0;
            echo_data_reg  <= 8'd0;
        end else begin
            echo_valid_reg <= echo_valid_next;
            echo_data_reg  <= echo_data_next;
        end
    end

    assign echo_valid     = echo_valid_reg;
    assign echo_data      = echo_data_reg;
    assign echo_busy_next = echo_valid_next;
`else
    logic unused_echo_ready;

    assign echo_valid        = 1'b0;
    assign echo_data         = 8'd0;
    assign echo_busy_next    = 1'b0;
    assign unused_echo_ready = echo_ready;
`endif

endmodule
